// File: rtl/aes_round_mixkey.sv
// AES-128 round back-end: column-serial MixColumns followed by AddRoundKey.
// One 128-bit block is accepted and processed one column per clock.
module aes_round_mixkey #(
  parameter logic KEY_XOR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic         in_final,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MIX  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] work_q, work_d;
  logic [127:0] key_q, key_d;
  logic         final_q, final_d;
  logic [127:0] out_state_q, out_state_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;

  logic [31:0]  col_s;
  logic [31:0]  key_col_s;
  logic [31:0]  mixed_s;
  logic [31:0]  new_col_s;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column; byte row 0 sits in the MSBs.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    mix_column = {b0, b1, b2, b3};
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_MIX;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MIX: begin
        if (col_cnt_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MIX;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs are registered from the next state.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_d)
      S_IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
      S_MIX: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
      S_DONE: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
      end
      default: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Column and key-column select driven by the column counter.
  always_comb begin
    col_s     = 32'h0000_0000;
    key_col_s = 32'h0000_0000;
    case (col_cnt_q)
      2'd0: begin
        col_s     = work_q[127:96];
        key_col_s = key_q[127:96];
      end
      2'd1: begin
        col_s     = work_q[95:64];
        key_col_s = key_q[95:64];
      end
      2'd2: begin
        col_s     = work_q[63:32];
        key_col_s = key_q[63:32];
      end
      2'd3: begin
        col_s     = work_q[31:0];
        key_col_s = key_q[31:0];
      end
      default: begin
        col_s     = 32'h0000_0000;
        key_col_s = 32'h0000_0000;
      end
    endcase
  end

  // Single shared MixColumns, bypassed on the final round, then key XOR.
  always_comb begin
    mixed_s = mix_column(col_s);
    if (final_q) begin
      new_col_s = col_s;
    end else begin
      new_col_s = mixed_s;
    end
    if (KEY_XOR_EN) begin
      new_col_s = new_col_s ^ key_col_s;
    end else begin
      new_col_s = new_col_s ^ 32'h0000_0000;
    end
  end

  // Datapath next-state: capture at accept, one column write per MIX cycle.
  always_comb begin
    work_d      = work_q;
    key_d       = key_q;
    final_d     = final_q;
    col_cnt_d   = col_cnt_q;
    out_state_d = out_state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d    = in_state;
          key_d     = in_key;
          final_d   = in_final;
          col_cnt_d = 2'd0;
        end else begin
          col_cnt_d = col_cnt_q;
        end
      end
      S_MIX: begin
        case (col_cnt_q)
          2'd0:    work_d[127:96] = new_col_s;
          2'd1:    work_d[95:64]  = new_col_s;
          2'd2:    work_d[63:32]  = new_col_s;
          2'd3:    work_d[31:0]   = new_col_s;
          default: work_d         = work_q;
        endcase
        col_cnt_d = col_cnt_q + 2'd1;
        // The result register is loaded once, on the last column write.
        if (col_cnt_q == 2'd3) begin
          out_state_d = work_d;
        end else begin
          out_state_d = out_state_q;
        end
      end
      S_DONE: begin
        col_cnt_d = col_cnt_q;
      end
      default: begin
        col_cnt_d = 2'd0;
      end
    endcase
  end

  // Datapath and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q      <= 128'd0;
      key_q       <= 128'd0;
      final_q     <= 1'b0;
      col_cnt_q   <= 2'd0;
      out_state_q <= 128'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      work_q      <= work_d;
      key_q       <= key_d;
      final_q     <= final_d;
      col_cnt_q   <= col_cnt_d;
      out_state_q <= out_state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;

endmodule
